// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 panel receiver: FSM states, default
// geometry and the colour bit offsets inside one 3-bit pixel slot.
package hub75_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } rxState_t;

  localparam int DEFAULT_COLS = 64;

  localparam int BIT_R = 2;
  localparam int BIT_G = 1;
  localparam int BIT_B = 0;

  // Pack one pixel as {R,G,B} using the offsets above.
  function automatic logic [2:0] packRgb(input logic r, input logic g, input logic b);
    logic [2:0] px;
    px        = '0;
    px[BIT_R] = r;
    px[BIT_G] = g;
    px[BIT_B] = b;
    return px;
  endfunction

endpackage

// File: rtl/hub75_sync.sv
// One-bit synchronizer with a rising-edge detector on the synchronized output.
// Every link input uses the same chain depth so data and edges stay aligned.
module hub75_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   qDly;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      qDly  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      qDly  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~qDly;

endmodule

// File: rtl/hub75_panel_rx.sv
// HUB75 receive side: emulates one 64-column dual-scan panel. Shifts the
// RGB0/RGB1 stream, commits a row pair on LAT and flags framing errors.
// Optional statistics counters are built when HUB75_RX_STATS_EN is defined.
// dbgState exposes the FSM state for observation.
module hub75_panel_rx
  import hub75_pkg::*;
#(
  parameter int COLS        = DEFAULT_COLS,
  parameter int ROW_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hub_clk,
  input  logic                LAT,
  input  logic                OE,
  input  logic                A,
  input  logic                B,
  input  logic                C,
  input  logic                D,
  input  logic                R0,
  input  logic                G0,
  input  logic                B0,
  input  logic                R1,
  input  logic                G1,
  input  logic                B1,
  output logic                row_valid,
  output logic [ROW_BITS-1:0] row_addr,
  output logic [3*COLS-1:0]   row_data0,
  output logic [3*COLS-1:0]   row_data1,
  output logic                short_err,
  output logic                long_err,
  output logic                blank_err,
  output logic                seq_err,
  output logic [15:0]         row_count,
  output logic [15:0]         err_count,
  output logic [1:0]          dbgState
);

  localparam int            CW       = $clog2(COLS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(COLS + 1);

  // Link bit order: {hub_clk, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1}
  logic [12:0] linkPins, linkSync, linkRise;
  assign linkPins = {hub_clk, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1};

  for (genvar i = 0; i < 13; i++) begin : gSync
    hub75_sync #(.SYNC_STAGES(SYNC_STAGES)) uSync (
      .clk  (clk),
      .rst  (rst),
      .d    (linkPins[i]),
      .q    (linkSync[i]),
      .rise (linkRise[i])
    );
  end

  logic unusedLink;
  assign unusedLink = ^{linkRise[10:0], linkSync[12:11]};

  logic                shiftRise, latRise, oeSync;
  logic [ROW_BITS-1:0] addrSync;
  logic [2:0]          rgb0, rgb1;
  assign shiftRise = linkRise[12];
  assign latRise   = linkRise[11];
  assign oeSync    = linkSync[10];
  assign addrSync  = ROW_BITS'(linkSync[9:6]);
  assign rgb0      = packRgb(linkSync[5], linkSync[4], linkSync[3]);
  assign rgb1      = packRgb(linkSync[2], linkSync[1], linkSync[0]);

  rxState_t state, stateNext;
  assign dbgState = state;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state: LAT wins over a shift edge; a shift in COMMIT starts the next row.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (latRise) stateNext = COMMIT;
               else if (shiftRise) stateNext = SHIFT;
      SHIFT:   if (latRise) stateNext = COMMIT;
      COMMIT:  stateNext = shiftRise ? SHIFT : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  logic [3*COLS-1:0] shReg0, shReg1;
  logic [CW-1:0]     shiftCnt;
  logic [ROW_BITS-1:0] latAddr, prevAddr;

  // Shift registers: newest pixel enters at column 0; cleared (or restarted) on COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shReg0   <= '0;
      shReg1   <= '0;
      shiftCnt <= '0;
    end else if (state == COMMIT) begin
      shReg0   <= shiftRise ? (3*COLS)'(rgb0) : '0;
      shReg1   <= shiftRise ? (3*COLS)'(rgb1) : '0;
      shiftCnt <= shiftRise ? CW'(1) : '0;
    end else if (shiftRise) begin
      shReg0   <= {shReg0[3*COLS-4:0], rgb0};
      shReg1   <= {shReg1[3*COLS-4:0], rgb1};
      shiftCnt <= (shiftCnt == CNT_SAT) ? shiftCnt : shiftCnt + CW'(1);
    end
  end

  // Capture the row address at the synchronized LAT rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) latAddr <= '0;
    else if (latRise) latAddr <= addrSync;
  end

  // Short rows are moved up so the first pixel lands in column COLS-1.
  logic [3*COLS-1:0] aligned0, aligned1;
  int unsigned       padBits;
  always_comb begin
    padBits = 0;
    if (shiftCnt < CNT_FULL) padBits = 3 * (COLS - int'(shiftCnt));
    aligned0 = shReg0 << padBits;
    aligned1 = shReg1 << padBits;
  end

  // Registered row outputs and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid <= 1'b0;
      row_addr  <= '0;
      row_data0 <= '0;
      row_data1 <= '0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
      seq_err   <= 1'b0;
      blank_err <= 1'b0;
      prevAddr  <= '1;
    end else begin
      row_valid <= 1'b0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
      seq_err   <= 1'b0;
      blank_err <= shiftRise & ~oeSync;
      if (state == COMMIT) begin
        row_valid <= 1'b1;
        row_addr  <= latAddr;
        row_data0 <= aligned0;
        row_data1 <= aligned1;
        short_err <= (shiftCnt < CNT_FULL);
        long_err  <= (shiftCnt > CNT_FULL);
        seq_err   <= (latAddr != prevAddr + ROW_BITS'(1));
        prevAddr  <= latAddr;
      end
    end
  end

`ifdef HUB75_RX_STATS_EN
  logic [15:0] rowCnt, errCnt;

  // Saturating row and error-cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowCnt <= '0;
      errCnt <= '0;
    end else begin
      if (row_valid && rowCnt != 16'hFFFF) rowCnt <= rowCnt + 16'd1;
      if ((short_err | long_err | blank_err | seq_err) && errCnt != 16'hFFFF)
        errCnt <= errCnt + 16'd1;
    end
  end

  assign row_count = rowCnt;
  assign err_count = errCnt;
`else
  assign row_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_hub75_panel_rx.sv
// Bench for hub75_panel_rx: directed rows, scoreboard queue of expected rows,
// monitor compares whenever row_valid is seen.
module tb_hub75_panel_rx;

  localparam int COLS = 64;
  localparam int W    = 3 * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hub_clk = 1'b0, LAT = 1'b0, OE = 1'b1;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
  logic R0 = 1'b0, G0 = 1'b0, B0 = 1'b0, R1 = 1'b0, G1 = 1'b0, B1 = 1'b0;
  logic          row_valid, short_err, long_err, blank_err, seq_err;
  logic [3:0]    row_addr;
  logic [W-1:0]  row_data0, row_data1;
  logic [15:0]   row_count, err_count;
  logic [1:0]    dbgState;

  hub75_panel_rx dut (
    .clk(clk), .rst(rst), .hub_clk(hub_clk), .LAT(LAT), .OE(OE),
    .A(A), .B(B), .C(C), .D(D),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .row_valid(row_valid), .row_addr(row_addr),
    .row_data0(row_data0), .row_data1(row_data1),
    .short_err(short_err), .long_err(long_err), .blank_err(blank_err), .seq_err(seq_err),
    .row_count(row_count), .err_count(err_count), .dbgState(dbgState)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]   addr;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         sh;
    logic         lg;
    logic         sq;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   expPrev = 15;
  int   expRows = 0;
  int   expErrs = 0;
  int   expBlank = 0;
  int   blankSeen = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare each committed row with the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (blank_err) blankSeen++;
      if (row_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_row: row_valid with addr %0d, nothing expected", row_addr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("row_addr",  W'(row_addr),  W'(e.addr));
          check("row_data0", row_data0,     e.d0);
          check("row_data1", row_data1,     e.d1);
          check("short_err", W'(short_err), W'(e.sh));
          check("long_err",  W'(long_err),  W'(e.lg));
          check("seq_err",   W'(seq_err),   W'(e.sq));
        end
      end else if (short_err || long_err || seq_err) begin
        fails++;
        $display("FAIL stray_err: short=%0b long=%0b seq=%0b without row_valid",
                 short_err, long_err, seq_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pat_bits(input int pat, input int k);
    logic [31:0] kv;
    kv = k;
    case (pat)
      0:       return 6'b100_000;
      1:       return {5'b0, kv[0]};
      default: return kv[5:0] ^ 6'b101_010;
    endcase
  endfunction

  task automatic set_pix(input logic [5:0] bits);
    {R0, G0, B0, R1, G1, B1} = bits;
  endtask

  task automatic shift_bit(input logic [5:0] bits, input logic oeLow);
    set_pix(bits);
    OE = ~oeLow;
    hub_clk = 1'b0;
    wait_clk(2);
    hub_clk = 1'b1;
    wait_clk(2);
    hub_clk = 1'b0;
    OE = 1'b1;
  endtask

  task automatic set_addr(input int addr);
    logic [3:0] a;
    a = 4'(addr);
    {D, C, B, A} = a;
  endtask

  task automatic do_latch(input int addr);
    set_addr(addr);
    wait_clk(2);
    LAT = 1'b1;
    wait_clk(3);
    LAT = 1'b0;
    wait_clk(3);
  endtask

  task automatic push_exp(input int addr, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic sh, input logic lg);
    exp_t e;
    e.addr = 4'(addr);
    e.d0   = e0;
    e.d1   = e1;
    e.sh   = sh;
    e.lg   = lg;
    e.sq   = (addr != ((expPrev + 1) % 16));
    expPrev = addr;
    expRows++;
    if (e.sh || e.lg || e.sq) expErrs++;
    exp_q.push_back(e);
  endtask

  // Shift n pixels of pattern pat, then latch addr. Bit k lands in column
  // 63-k for n<=64, or n-1-k for longer rows (oldest bits fall off).
  task automatic send_row(input int addr, input int n, input int pat, input int oeLowIdx);
    logic [W-1:0] e0, e1;
    logic [5:0]   bits;
    int           col;
    e0 = '0;
    e1 = '0;
    for (int k = 0; k < n; k++) begin
      bits = pat_bits(pat, k);
      col  = (n <= COLS) ? (COLS - 1 - k) : (n - 1 - k);
      if (col >= 0 && col < COLS) begin
        e0[3*col +: 3] = bits[5:3];
        e1[3*col +: 3] = bits[2:0];
      end
      if (k == oeLowIdx) begin
        expBlank++;
        expErrs++;
      end
      shift_bit(bits, k == oeLowIdx);
    end
    push_exp(addr, e0, e1, n < COLS, n > COLS);
    do_latch(addr);
  endtask

  // 64th shift edge and LAT rise on the same pin edge.
  task automatic send_row_coincident(input int addr, input int pat);
    logic [W-1:0] e0, e1;
    logic [5:0]   bits;
    e0 = '0;
    e1 = '0;
    for (int k = 0; k < COLS; k++) begin
      bits = pat_bits(pat, k);
      e0[3*(COLS-1-k) +: 3] = bits[5:3];
      e1[3*(COLS-1-k) +: 3] = bits[2:0];
      if (k < COLS - 1) shift_bit(bits, 1'b0);
    end
    push_exp(addr, e0, e1, 1'b0, 1'b0);
    set_pix(bits);
    set_addr(addr);
    wait_clk(2);
    hub_clk = 1'b1;
    LAT = 1'b1;
    wait_clk(3);
    hub_clk = 1'b0;
    LAT = 1'b0;
    wait_clk(3);
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      wait_clk(1);
      budget--;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d rows still expected after timeout", exp_q.size());
      exp_q.delete();
    end
    wait_clk(4);
  endtask

  task automatic check_stats(input string tag);
`ifdef HUB75_RX_STATS_EN
    check({tag, "_row_count"}, W'(row_count), W'(expRows));
    check({tag, "_err_count"}, W'(err_count), W'(expErrs));
`else
    check({tag, "_row_count"}, W'(row_count), '0);
    check({tag, "_err_count"}, W'(err_count), '0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    check({tag, "_row_valid"}, W'(row_valid), '0);
    check({tag, "_row_addr"},  W'(row_addr),  '0);
    check({tag, "_row_data0"}, row_data0,     '0);
    check({tag, "_row_data1"}, row_data1,     '0);
    check({tag, "_errs"},      W'({short_err, long_err, blank_err, seq_err}), '0);
    check({tag, "_state"},     W'(dbgState),  '0);
    check_stats(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] allRed;
    allRed = {COLS{3'b100}};

    wait_clk(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    wait_clk(4);

    // all-red upper row at address 0
    send_row(0, 64, 0, -1);
    drain();
    check("t1_const_data0", row_data0, allRed);
    check("t1_const_data1", row_data1, '0);

    // in-order rows 1..4, then the B1 = k[0] pattern at 5
    for (int r = 1; r <= 4; r++) send_row(r, 64, 2, -1);
    send_row(5, 64, 1, -1);
    drain();
    check("t2_col0_b1",  W'(row_data1[0]),      W'(1'b1));
    check("t2_col63_b1", W'(row_data1[3*63]),   W'(1'b0));

    // short and long rows
    send_row(6, 10, 2, -1);
    send_row(7, 70, 2, -1);
    // shift with OE low
    send_row(8, 64, 2, 0);
    // sequence breaks and wraparound
    send_row(3, 64, 0, -1);
    send_row(7, 64, 1, -1);
    send_row(15, 64, 2, -1);
    send_row(0, 64, 0, -1);
    // LAT coincident with the 64th shift edge
    send_row_coincident(1, 2);
    // LAT with no shifts at all
    push_exp(2, '0, '0, 1'b1, 1'b0);
    do_latch(2);
    drain();
    check("blank_pulses", W'(blankSeen), W'(expBlank));
    check_stats("mid");

    // reset in the middle of a row
    for (int k = 0; k < 30; k++) shift_bit(pat_bits(2, k), 1'b0);
    rst = 1'b1;
    expPrev = 15;
    expRows = 0;
    expErrs = 0;
    wait_clk(3);
    check_idle_outputs("midrow_rst");
    rst = 1'b0;
    wait_clk(6);
    send_row(0, 64, 0, -1);
    drain();
    check("post_rst_data0", row_data0, allRed);
    check_stats("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
